// File: rtl/lti_sample_driver_if.sv
// Signal bundle between the sample scheduler and its environment: control, filter-side
// strobe/sample pair, result stream and sticky flags. LTI_DRV_STATS_EN adds event counters.
interface lti_sample_driver_if #(
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int DW = 16
);
  logic          enable;
  logic [DW-1:0] period;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          ce_to_sys;
  logic [IW-1:0] sig_to_sys;
  logic          ce_from_sys;
  logic [OW-1:0] sig_from_sys;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          underrun;
  logic          overrun;
  logic          timeout;
  logic          clr_flags;
`ifdef LTI_DRV_STATS_EN
  logic [15:0]   underrun_cnt;
  logic [15:0]   overrun_cnt;
  logic [15:0]   timeout_cnt;

  modport master (
    input  enable, period, in_valid, in_data, ce_from_sys, sig_from_sys, out_ready, clr_flags,
    output in_ready, ce_to_sys, sig_to_sys, out_valid, out_data, underrun, overrun, timeout,
    output underrun_cnt, overrun_cnt, timeout_cnt
  );
  modport slave (
    output enable, period, in_valid, in_data, ce_from_sys, sig_from_sys, out_ready, clr_flags,
    input  in_ready, ce_to_sys, sig_to_sys, out_valid, out_data, underrun, overrun, timeout,
    input  underrun_cnt, overrun_cnt, timeout_cnt
  );
`else
  modport master (
    input  enable, period, in_valid, in_data, ce_from_sys, sig_from_sys, out_ready, clr_flags,
    output in_ready, ce_to_sys, sig_to_sys, out_valid, out_data, underrun, overrun, timeout
  );
  modport slave (
    output enable, period, in_valid, in_data, ce_from_sys, sig_from_sys, out_ready, clr_flags,
    input  in_ready, ce_to_sys, sig_to_sys, out_valid, out_data, underrun, overrun, timeout
  );
`endif
endinterface

// File: rtl/lti_sample_driver.sv
// Periodic ce-strobe scheduler for a ce-strobed filter: one sample out per tick, one result
// captured per returned strobe. Define LTI_DRV_STATS_EN for saturating event counters.
module lti_sample_driver #(
  parameter int IW      = 16,
  parameter int OW      = 16,
  parameter int DW      = 16,
  parameter int TW      = 8,
  parameter int LAT_MAX = 16
) (
  input logic                 clk,
  input logic                 rst,
  lti_sample_driver_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_period;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_period_eff;
  logic [TW-1:0] r_tmr;
  logic          r_ce;
  logic [IW-1:0] r_sig;
  logic          r_out_valid;
  logic [OW-1:0] r_out_data;
  logic          r_underrun;
  logic          r_overrun;
  logic          r_timeout;

  logic w_tick, w_resp, w_tmo, w_free, w_issue, w_miss, w_drop, w_accept;
  logic w_under_ev, w_over_ev;

  assign w_period_eff = (bus.period < DW'(2)) ? DW'(2) : bus.period;
  assign w_tick   = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_resp   = (r_state == S_WAIT) && bus.ce_from_sys;
  assign w_tmo    = (r_state == S_WAIT) && !bus.ce_from_sys && (r_tmr == TW'(LAT_MAX - 1));
  // A transaction that resolves on this clock frees the slot for a same-clock tick.
  assign w_free   = (r_state == S_RUN) || w_resp || w_tmo;
  assign w_issue  = w_tick && w_free && bus.enable;
  assign w_miss   = w_tick && (r_state == S_WAIT) && !w_resp && !w_tmo;
  assign w_accept = r_out_valid && bus.out_ready;
  assign w_drop   = w_resp && r_out_valid && !bus.out_ready;

  assign w_under_ev = w_issue && !bus.in_valid;
  assign w_over_ev  = w_miss || w_drop;

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.enable) w_next_state = S_RUN;
      S_RUN: begin
        if (!bus.enable)  w_next_state = S_IDLE;
        else if (w_issue) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_resp || w_tmo) begin
          if (!bus.enable)  w_next_state = S_IDLE;
          else if (w_issue) w_next_state = S_WAIT;
          else              w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_cnt    <= '0;
      r_tmr    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) begin
        if (bus.enable) begin
          r_period <= w_period_eff;
          r_cnt    <= w_period_eff - DW'(1);
        end
      end else if (w_tick) begin
        r_cnt <= r_period - DW'(1);
      end else begin
        r_cnt <= r_cnt - DW'(1);
      end
      if (w_issue)                r_tmr <= '0;
      else if (r_state == S_WAIT) r_tmr <= r_tmr + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce        <= 1'b0;
      r_sig       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_ce <= w_issue;
      if (w_issue && bus.in_valid) r_sig <= bus.in_data;

      if (w_resp) begin
        r_out_data  <= bus.sig_from_sys;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end

      if (bus.clr_flags) begin
        r_underrun <= 1'b0;
        r_overrun  <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_under_ev) r_underrun <= 1'b1;
        if (w_over_ev)  r_overrun  <= 1'b1;
        if (w_tmo)      r_timeout  <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_issue && bus.in_valid;
  assign bus.ce_to_sys  = r_ce;
  assign bus.sig_to_sys = r_sig;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.underrun   = r_underrun;
  assign bus.overrun    = r_overrun;
  assign bus.timeout    = r_timeout;

`ifdef LTI_DRV_STATS_EN
  logic [15:0] r_underrun_cnt;
  logic [15:0] r_overrun_cnt;
  logic [15:0] r_timeout_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
    return (ev && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || bus.clr_flags) begin
      r_underrun_cnt <= '0;
      r_overrun_cnt  <= '0;
      r_timeout_cnt  <= '0;
    end else begin
      r_underrun_cnt <= sat_inc(r_underrun_cnt, w_under_ev);
      r_overrun_cnt  <= sat_inc(r_overrun_cnt, w_over_ev);
      r_timeout_cnt  <= sat_inc(r_timeout_cnt, w_tmo);
    end
  end

  assign bus.underrun_cnt = r_underrun_cnt;
  assign bus.overrun_cnt  = r_overrun_cnt;
  assign bus.timeout_cnt  = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_lti_sample_driver.sv
// Directed bench for lti_sample_driver: a vector table of scheduling scenarios against a
// delay-line filter model, plus hand-written underrun, timeout, skid and reset sequences.
module tb_lti_sample_driver;

  logic clk;
  logic rst;

  lti_sample_driver_if #(.IW(16), .OW(16), .DW(16)) drv_if ();

  lti_sample_driver #(.IW(16), .OW(16), .DW(16), .TW(8), .LAT_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (drv_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter model: returns ~sample on ce_out m_lat clocks after ce_in; m_lat < 0 never answers.
  int          m_lat = -1;
  logic [7:0]  m_pipe = '0;
  logic [15:0] m_dpipe [8];
  logic        m_ce = 1'b0;
  logic [15:0] m_dat = '0;
  logic        stray_ce;

  always @(negedge clk) begin
    for (int k = 7; k > 0; k--) begin
      m_pipe[k]  = m_pipe[k-1];
      m_dpipe[k] = m_dpipe[k-1];
    end
    m_pipe[0]  = drv_if.ce_to_sys;
    m_dpipe[0] = drv_if.sig_to_sys;
    if (m_lat >= 0) begin
      m_ce  = m_pipe[m_lat];
      m_dat = ~m_dpipe[m_lat];
    end else begin
      m_ce = 1'b0;
    end
  end

  assign drv_if.ce_from_sys  = m_ce | stray_ce;
  assign drv_if.sig_from_sys = m_ce ? m_dat : (stray_ce ? 16'h5555 : 16'hDEAD);

  int n_rdy = 0;
  always @(negedge clk) if (drv_if.in_ready) n_rdy++;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (drv_if.ce_to_sys) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    drv_if.enable    = 1'b0;
    drv_if.period    = '0;
    drv_if.in_valid  = 1'b1;
    drv_if.in_data   = '0;
    drv_if.out_ready = 1'b1;
    drv_if.clr_flags = 1'b0;
    stray_ce         = 1'b0;
    tick(10);
    rst = 1'b0;
  endtask

  typedef struct {
    int          period;
    int          lat;
    logic [15:0] din;
    int          exp_first;
    int          exp_gap;
    int          exp_olat;
    logic [15:0] exp_out;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int c1, c2, cov, n, r0;
    logic [15:0] dov, sig1;
    logic seen;

    vecs[0] = '{period: 10, lat: 3, din: 16'h1234, exp_first: 10, exp_gap: 10, exp_olat: 4, exp_out: 16'hEDCB, exp_ovr: 1'b0};
    vecs[1] = '{period:  0, lat: 3, din: 16'h0F0F, exp_first:  2, exp_gap:  4, exp_olat: 4, exp_out: 16'hF0F0, exp_ovr: 1'b1};
    vecs[2] = '{period:  1, lat: 1, din: 16'h8001, exp_first:  2, exp_gap:  2, exp_olat: 2, exp_out: 16'h7FFE, exp_ovr: 1'b0};
    vecs[3] = '{period:  5, lat: 0, din: 16'h00FF, exp_first:  5, exp_gap:  5, exp_olat: 1, exp_out: 16'hFF00, exp_ovr: 1'b0};
    vecs[4] = '{period:  3, lat: 4, din: 16'hA5A5, exp_first:  3, exp_gap:  6, exp_olat: 5, exp_out: 16'h5A5A, exp_ovr: 1'b1};

    do_reset();
    check("rst_ce_to_sys", drv_if.ce_to_sys, 0);
    check("rst_sig_to_sys", drv_if.sig_to_sys, 0);
    check("rst_out_valid", drv_if.out_valid, 0);
    check("rst_out_data", drv_if.out_data, 0);
    check("rst_in_ready", drv_if.in_ready, 0);
    check("rst_flags", {drv_if.underrun, drv_if.overrun, drv_if.timeout}, 0);

    // Vector table: strobe timing, capture latency and flags per scenario.
    for (int v = 0; v < 5; v++) begin
      m_lat = vecs[v].lat;
      do_reset();
      drv_if.period  = 16'(vecs[v].period);
      drv_if.in_data = vecs[v].din;
      drv_if.enable  = 1'b1;
      c1 = -1; c2 = -1; cov = -1; dov = '0; sig1 = '0;
      for (int c = 1; c <= 60; c++) begin
        tick(1);
        if (drv_if.ce_to_sys) begin
          if (c1 < 0) begin
            c1   = c;
            sig1 = drv_if.sig_to_sys;
          end else if (c2 < 0) begin
            c2 = c;
          end
        end
        if (c1 >= 0 && cov < 0 && drv_if.out_valid) begin
          cov = c;
          dov = drv_if.out_data;
        end
      end
      check($sformatf("v%0d_first_strobe", v), c1 - 1, vecs[v].exp_first);
      check($sformatf("v%0d_strobe_gap", v), c2 - c1, vecs[v].exp_gap);
      check($sformatf("v%0d_out_latency", v), cov - c1, vecs[v].exp_olat);
      check($sformatf("v%0d_out_data", v), dov, vecs[v].exp_out);
      check($sformatf("v%0d_sig_to_sys", v), sig1, vecs[v].din);
      check($sformatf("v%0d_underrun", v), drv_if.underrun, 0);
      check($sformatf("v%0d_overrun", v), drv_if.overrun, vecs[v].exp_ovr);
      check($sformatf("v%0d_timeout", v), drv_if.timeout, 0);
    end

    // Underrun: in_valid low at the second tick.
    m_lat = 1;
    do_reset();
    drv_if.period  = 16'd4;
    drv_if.in_data = 16'hAAAA;
    r0 = n_rdy;
    drv_if.enable  = 1'b1;
    wait_strobe(50, n);
    check("ur_first_sig", drv_if.sig_to_sys, 16'hAAAA);
    drv_if.in_valid = 1'b0;
    drv_if.in_data  = 16'hBBBB;
    wait_strobe(50, n);
    check("ur_second_gap", n, 4);
    check("ur_sig_held", drv_if.sig_to_sys, 16'hAAAA);
    check("ur_underrun", drv_if.underrun, 1);
    check("ur_in_ready_pulses", n_rdy - r0, 1);

    // Timeout: filter never answers; stray ce 20 clocks after the strobe is ignored.
    m_lat = -1;
    do_reset();
    drv_if.period = 16'd30;
    drv_if.enable = 1'b1;
    wait_strobe(100, n);
    check("to_strobe_seen", n, 31);
    tick(15);
    check("to_before_16", drv_if.timeout, 0);
    tick(1);
    check("to_at_16", drv_if.timeout, 1);
    tick(3);
    stray_ce = 1'b1;
    tick(1);
    stray_ce = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (drv_if.out_valid) seen = 1'b1;
      tick(1);
    end
    check("to_stray_ignored", seen, 0);
    wait_strobe(50, n);
    check("to_next_strobe", n + 5, 10);
    check("to_no_overrun", drv_if.overrun, 0);
`ifdef LTI_DRV_STATS_EN
    check("to_timeout_cnt", drv_if.timeout_cnt, 1);
`endif

    // Skid: downstream stalled over two results, then clear racing a new overrun.
    m_lat = 3;
    do_reset();
    drv_if.period    = 16'd10;
    drv_if.in_data   = 16'h1111;
    drv_if.out_ready = 1'b0;
    drv_if.enable    = 1'b1;
    wait_strobe(50, n);
    drv_if.in_data = 16'h2222;
    wait_strobe(50, n);
    check("sk_first_held", drv_if.out_data, 16'hEEEE);
    check("sk_first_valid", drv_if.out_valid, 1);
    check("sk_no_ovr_yet", drv_if.overrun, 0);
    drv_if.in_data = 16'h3333;
    tick(4);
    check("sk_second_data", drv_if.out_data, 16'hDDDD);
    check("sk_overrun", drv_if.overrun, 1);
    wait_strobe(50, n);
    tick(3);
    drv_if.clr_flags = 1'b1;
    tick(1);
    drv_if.clr_flags = 1'b0;
    check("sk_clr_wins", drv_if.overrun, 0);
    check("sk_third_data", drv_if.out_data, 16'hCCCC);
    drv_if.out_ready = 1'b1;
    tick(1);
    check("sk_accepted", drv_if.out_valid, 0);

    // Reset in WAIT: outputs clear, late response ignored, schedule restarts.
    m_lat = 3;
    do_reset();
    drv_if.period  = 16'd10;
    drv_if.in_data = 16'h4321;
    drv_if.enable  = 1'b1;
    wait_strobe(50, n);
    wait_strobe(50, n);
    tick(2);
    check("rw_pre_data", drv_if.out_data, 16'hBCDE);
    rst           = 1'b1;
    drv_if.enable = 1'b0;
    tick(1);
    rst = 1'b0;
    check("rw_ce_to_sys", drv_if.ce_to_sys, 0);
    check("rw_sig_to_sys", drv_if.sig_to_sys, 0);
    check("rw_out_valid", drv_if.out_valid, 0);
    check("rw_out_data", drv_if.out_data, 0);
    check("rw_flags", {drv_if.underrun, drv_if.overrun, drv_if.timeout}, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (drv_if.out_valid) seen = 1'b1;
    end
    check("rw_late_ce_ignored", seen, 0);
    drv_if.enable = 1'b1;
    wait_strobe(50, n);
    check("rw_restart_period", n - 1, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lti_sample_driver.md
Name: lti_sample_driver

Overview:
- Host-side sample scheduler for the ce-strobed state-space filter blocks (e.g. lti_system).
- Generates the periodic ce strobe toward the filter and presents one input sample per strobe.
- Captures the filter output on its returned ce strobe.
- Hands captured results to downstream logic over a valid/ready stream; flags overruns, underruns and latency timeouts.

Parameters:
- IW, 16, width of samples sent to the filter.
- OW, 16, width of samples returned by the filter.
- DW, 16, width of the sample-period divider.
- TW, 8, width of the response-timeout counter.
- LAT_MAX, 16, maximum clocks from issued strobe to returned strobe before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  run the scheduler; 0 means return to IDLE after the current transaction.
- period  in  DW  sample period in clocks; sampled when leaving IDLE; values 0 and 1 are treated as 2.
- in_valid  in  1  upstream sample available.
- in_data  in  IW  upstream sample.
- in_ready  out  1  one-cycle pulse; in_data consumed this cycle.
- ce_to_sys  out  1  one-cycle strobe to the filter ce_in.
- sig_to_sys  out  IW  sample to the filter; registered and stable from the strobe until the next strobe.
- ce_from_sys  in  1  filter ce_out.
- sig_from_sys  in  OW  filter output; valid only while ce_from_sys=1.
- out_valid  out  1  captured result valid.
- out_data  out  OW  captured result.
- out_ready  in  1  downstream accepts the result.
- underrun  out  1  sticky: a tick occurred with in_valid=0.
- overrun  out  1  sticky: a tick occurred while still awaiting a response, or a result was dropped.
- timeout  out  1  sticky: no response within LAT_MAX clocks.
- clr_flags  in  1  clears the sticky flags; has priority over a same-cycle set.

Behaviour:
- Reset values: all outputs 0; sig_to_sys=0; state IDLE; tick counter=0.
- States:
  - IDLE: on enable=1, latch max(period,2) into P, load tick counter with P-1, go to RUN.
  - RUN: counter decrements each clock; at 0 a tick fires and the counter reloads P-1.
  - On tick with no response pending:
    - If in_valid=1: register in_data to sig_to_sys and pulse in_ready.
    - If in_valid=0: hold the previous sig_to_sys and set underrun.
    - Same clock: assert ce_to_sys for exactly 1 cycle, go to WAIT.
  - WAIT: tick counter keeps running; response timer counts from 0.
    - On ce_from_sys=1: capture sig_from_sys into out_data, go to RUN.
    - If the timer reaches LAT_MAX: set timeout, go to RUN; a later stray ce_from_sys is ignored.
    - Tick in WAIT: no strobe is issued, no input is consumed, overrun is set; the next strobe waits for the next tick.
- Throughput and latency:
  - At most one transaction is outstanding.
  - Latency from ce_to_sys to out_valid = filter latency + 1 clock (capture is registered).
- Result register is a single-entry skid:
  - out_valid stays high until out_valid & out_ready.
  - If a new capture arrives while out_valid=1 and out_ready=0: the new value overwrites, overrun is set.
  - Capture and accept in the same cycle: the new value is loaded, out_valid stays 1, no overrun.
- enable dropped in RUN: go to IDLE immediately.
- enable dropped in WAIT: finish the transaction (response or timeout), then go to IDLE. Already-captured results remain deliverable.
- Reset mid-WAIT: the transaction is abandoned and out_valid cleared. A ce_from_sys arriving after reset is ignored because the state is IDLE.
- ce_from_sys outside WAIT is ignored.

Optional Feature:
- Macro LTI_DRV_STATS_EN.
- When defined, adds three 16-bit saturating counters: underrun_cnt, overrun_cnt, timeout_cnt.
  - Output ports; each increments on its event; saturates at 0xFFFF; cleared by rst and clr_flags.
- When undefined, these ports and counters do not exist; the sticky flags are unchanged either way.

Test Plan:
- period=10, in_valid=1, filter model latency 3, enable=1, out_ready=1:
  - ce_to_sys every 10 clocks; in_data 0x1234 appears on sig_to_sys.
  - out_valid pulses 4 clocks after each strobe with the model output; no flags set.
- period=0:
  - Strobes every 2 clocks.
  - With filter latency 3, overrun=1 and strobes drop to every 4th clock.
- in_valid=0 at the second tick:
  - underrun=1; sig_to_sys holds the first sample; strobe still issued; in_ready not pulsed.
- Filter model never returns ce, LAT_MAX=16:
  - timeout=1 exactly 16 clocks after the strobe; the next tick issues a new strobe.
  - A stray ce_from_sys at clock 20 is ignored.
- out_ready=0 for two transactions:
  - out_data holds the second result; overrun=1.
  - clr_flags pulsed in the same cycle as a new overrun leaves overrun=0.
- rst asserted in WAIT, then enable=1 again:
  - All outputs are 0 after reset; the late ce_from_sys produces no out_valid.
  - Scheduling restarts with the first strobe period clocks after enable.
